// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared core constants and fetch state encoding
// Purpose: common widths, instruction size, default reset PC and the fetch
//          stage state type used by the RISC-V core front end.
// Ports:   none (package)
package riscv_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch stage with redirect and fault trapping
// Purpose: owns the PC, drives the word-aligned fetch address into a zero-latency
//          program memory, registers the fetched word with its PC and hands it to
//          decode over a valid/ready handshake. Illegal redirects and running off
//          the end of program memory trap into a sticky FAULT state.
// Ports:
//   clk            in   1     rising-edge clock
//   rst            in   1     synchronous active-high reset
//   imem_addr      out  XLEN  fetch byte address (current PC)
//   imem_data      in   XLEN  instruction word at imem_addr (combinational)
//   redirect_valid in   1     execute requests a PC change
//   redirect_pc    in   XLEN  redirect target byte address
//   out_valid      out  1     out_instr/out_pc hold a fetched instruction
//   out_ready      in   1     decode accepts the output
//   out_instr      out  XLEN  fetched instruction word
//   out_pc         out  XLEN  byte address of out_instr
//   fault          out  1     sticky misaligned / out-of-range fetch flag
//   fetch_count    out  32    completed output transfers (wraps)
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              MEM_SIZE = 256
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            fault,
  output logic [31:0]     fetch_count
);

  // One bit wider than the PC so the limit stays exact even if the memory
  // spans the whole address space.
  localparam logic [XLEN:0] PC_LIMIT =
    (XLEN+1)'(MEM_SIZE) * (XLEN+1)'(INSTR_BYTES);

  fetch_state_t    state;
  logic [XLEN-1:0] pc_q;

  logic redirect_illegal;
  logic pc_out_of_range;
  logic load;
  logic transfer;

  assign imem_addr = pc_q;

  assign redirect_illegal = (redirect_pc[1:0] != 2'b00) ||
                            ({1'b0, redirect_pc} >= PC_LIMIT);
  assign pc_out_of_range  = ({1'b0, pc_q} >= PC_LIMIT);

  // load never looks at anything but registered state and out_ready feeding
  // a register, so there is no combinational ready->valid path.
  assign load     = !out_valid || out_ready;
  assign transfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc_q        <= RESET_PC;
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_pc      <= '0;
      fault       <= 1'b0;
      fetch_count <= '0;
    end else begin
      // A transfer completes on this edge even if a redirect flushes the
      // register at the same time. In FAULT out_valid is low, so the counter
      // is naturally frozen there.
      if (transfer) begin
        fetch_count <= fetch_count + 32'd1;
      end

      if (state == RUN) begin
        if (redirect_valid && redirect_illegal) begin
          // pc_q keeps the last legal fetch address for post-mortem.
          state     <= FAULT;
          fault     <= 1'b1;
          out_valid <= 1'b0;
        end else if (redirect_valid) begin
          // Flush: imem_data still belongs to the old path, so nothing is
          // captured; the target word is fetched next cycle.
          pc_q      <= redirect_pc;
          out_valid <= 1'b0;
        end else if (pc_out_of_range) begin
          // Takes precedence over a stall, so a pending output is dropped.
          state     <= FAULT;
          fault     <= 1'b1;
          out_valid <= 1'b0;
        end else if (load) begin
          out_valid <= 1'b1;
          out_instr <= imem_data;
          out_pc    <= pc_q;
          pc_q      <= pc_q + XLEN'(INSTR_BYTES);
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch with reference model
module tb_instr_fetch;
  import riscv_pkg::*;

  localparam int          MEM_SIZE = 256;
  localparam logic [31:0] LIMIT    = 32'(MEM_SIZE * 4);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_ready = 1'b0;
  logic [31:0] imem_addr, imem_data, out_instr, out_pc, fetch_count;
  logic        out_valid, fault;

  logic [31:0] mem [MEM_SIZE];

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  bit          m_init  = 1'b0;
  bit          m_fault = 1'b0;
  bit          m_valid = 1'b0;
  logic [31:0] m_pc, m_opc, m_oinstr, m_count;
  logic [63:0] exp_q [$];

  always #5 clk = ~clk;

  assign imem_data = (imem_addr < LIMIT) ? mem[imem_addr[9:2]] : 32'hdead_beef;

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .MEM_SIZE (MEM_SIZE)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault),
    .fetch_count    (fetch_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a < LIMIT) ? mem[a[9:2]] : 32'hdead_beef;
  endfunction

  // Reference model: applies the fetch rules to the inputs seen at each edge
  // and queues every transfer it predicts.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_init = 1'b1; m_fault = 1'b0; m_valid = 1'b0;
        m_pc = 32'h0; m_opc = 32'h0; m_oinstr = 32'h0; m_count = 32'h0;
      end else if (m_init) begin
        if (m_valid && out_ready) begin
          m_count = m_count + 1;
          exp_q.push_back({m_opc, m_oinstr});
        end
        if (!m_fault) begin
          if (redirect_valid && (redirect_pc % 4 != 0 || redirect_pc >= LIMIT)) begin
            m_fault = 1'b1; m_valid = 1'b0;
          end else if (redirect_valid) begin
            m_pc = redirect_pc; m_valid = 1'b0;
          end else if (m_pc >= LIMIT) begin
            m_fault = 1'b1; m_valid = 1'b0;
          end else if (!m_valid || out_ready) begin
            m_valid = 1'b1; m_opc = m_pc; m_oinstr = word_at(m_pc); m_pc = m_pc + 4;
          end
        end
      end
    end
  end

  // Monitor: per-cycle state comparison plus scoreboard pop on each transfer.
  initial begin
    logic [31:0] cap_pc, cap_instr;
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (m_init) begin
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("fault", 32'(fault), 32'(m_fault));
        check("fetch_count", fetch_count, m_count);
        check("imem_addr", imem_addr, m_pc);
        if (m_valid) begin
          check("out_pc", out_pc, m_opc);
          check("out_instr", out_instr, m_oinstr);
        end
      end
      if (!rst && out_valid === 1'b1 && out_ready) begin
        cap_pc    = out_pc;
        cap_instr = out_instr;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL xfer_unexpected: transfer pc=%h with no expected entry", cap_pc);
        end else begin
          e = exp_q.pop_front();
          check("xfer_pc", cap_pc, e[63:32]);
          check("xfer_instr", cap_instr, e[31:0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  task automatic step(input bit r, input bit rv, input logic [31:0] rpc, input bit rdy);
    rst = r; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [31:0] last_pc;
    int          fault_age;

    mem[0] = 32'h200000b7;
    mem[1] = 32'h00100113;
    mem[2] = 32'h0020a023;
    for (int i = 3; i < MEM_SIZE; i++) mem[i] = $urandom;

    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_count", fetch_count, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_imem_addr", imem_addr, 32'd0);

    // first fetch one cycle after reset release, then streaming
    step(0, 0, 0, 1);
    check("seq_valid0", 32'(out_valid), 32'd1);
    check("seq_pc0", out_pc, 32'h0);
    check("seq_instr0", out_instr, 32'h200000b7);
    step(0, 0, 0, 1);
    check("seq_pc1", out_pc, 32'h4);
    check("seq_instr1", out_instr, 32'h00100113);

    // backpressure at pc 4
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      check("stall_instr", out_instr, 32'h00100113);
      check("stall_addr", imem_addr, 32'h8);
      check("stall_count", fetch_count, 32'd1);
    end
    step(0, 0, 0, 1);
    check("release_pc", out_pc, 32'h8);
    check("release_instr", out_instr, 32'h0020a023);
    step(0, 0, 0, 1);
    check("count_3", fetch_count, 32'd3);

    // redirect back to 0 while 0x14 is presented
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check("pre_redirect_pc", out_pc, 32'h14);
    step(0, 1, 32'h0, 1);
    check("flush_valid", 32'(out_valid), 32'd0);
    step(0, 0, 0, 1);
    check("redirect_pc", out_pc, 32'h0);
    check("redirect_instr", out_instr, 32'h200000b7);

    // misaligned redirect traps; everything ignored until reset
    step(0, 1, 32'h6, 1);
    check("mis_fault", 32'(fault), 32'd1);
    check("mis_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step(0, i[0], 32'h10, (i % 3) != 0);
      check("fault_sticky", 32'(fault), 32'd1);
      check("fault_no_valid", 32'(out_valid), 32'd0);
    end
    step(1, 0, 0, 1);
    check("fault_cleared", 32'(fault), 32'd0);
    step(0, 0, 0, 1);
    check("after_fault_pc", out_pc, 32'h0);
    check("after_fault_valid", 32'(out_valid), 32'd1);

    // run off the end of program memory
    step(0, 1, 32'h3F0, 1);
    last_pc = 32'hffff_ffff;
    for (int i = 0; i < 12 && !fault; i++) begin
      step(0, 0, 0, 1);
      if (out_valid) last_pc = out_pc;
    end
    check("end_last_pc", last_pc, 32'h3FC);
    check("end_fault", 32'(fault), 32'd1);

    // reset mid-stream with a pending transfer
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    check("midrst_count", fetch_count, 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    step(0, 0, 0, 1);
    check("midrst_restart_pc", out_pc, 32'h0);

    // randomized traffic
    fault_age = 0;
    for (int c = 0; c < 4000; c++) begin
      int          sel;
      bit          r, rv, rdy;
      logic [31:0] t;
      sel = $urandom_range(0, 999);
      r = 1'b0; rv = 1'b0; t = 32'h0;
      rdy = ($urandom_range(0, 3) != 0);
      fault_age = m_fault ? fault_age + 1 : 0;
      if (fault_age > 6 || sel >= 995) r = 1'b1;
      else if (sel < 30) begin rv = 1'b1; t = 32'($urandom_range(0, 255)) << 2; end
      else if (sel < 40) begin rv = 1'b1; t = 32'($urandom_range(240, 255)) << 2; end
      else if (sel < 43) begin rv = 1'b1; t = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3)); end
      else if (sel < 46) begin rv = 1'b1; t = LIMIT + (32'($urandom_range(0, 64)) << 2); end
      step(r, rv, t, rdy);
    end

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("xfer_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
